// File: rtl/rtc_write_sequencer_if.sv
// Sequencer control/bus bundle: the control FSM side is the master and the
// write sequencer is the slave.
interface rtc_seq_if #(
  parameter int N_REGS = 10,
  parameter int ADDR_W = 4,
  parameter int SEL_W  = 4
);
  logic              start;
  logic [N_REGS-1:0] reg_mask;
  logic              busy;
  logic              fin;
  logic              op;
  logic              wr;
  logic              ad;
  logic [ADDR_W-1:0] addr_out;
  logic [SEL_W-1:0]  sel_prog;
  logic [1:0]        data_sel;
  logic              init_read;

  modport master (
    output start, reg_mask,
    input  busy, fin, op, wr, ad, addr_out, sel_prog, data_sel, init_read
  );

  modport slave (
    input  start, reg_mask,
    output busy, fin, op, wr, ad, addr_out, sel_prog, data_sel, init_read
  );
endinterface

// File: rtl/rtc_write_sequencer.sv
// Self-sequencing RTC bus write: control register preamble, each enabled register, then fin.
// Optional read-start pulse after fin is enabled by defining RTC_SEQ_READ_KICK_EN.
module rtc_write_sequencer #(
  parameter int N_REGS       = 10,
  parameter int ADDR_W       = 4,
  parameter int SEL_W        = 4,
  parameter int BASE_ADDR    = 4,
  parameter int CTRL_ADDR    = 0,
  parameter int PHASE_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  rtc_seq_if.slave bus
);

  localparam int PH_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(PHASE_CYCLES - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_REGS - 1);

  // The scan step is folded into the PRE_D/REG_D exits, so it has no state of its own.
  typedef enum logic [2:0] {IDLE, PRE_A, PRE_D, REG_A, REG_D, FIN} state_t;

  state_t            state;
  logic [N_REGS-1:0] mask;
  logic [PH_W-1:0]   phase_cnt;
  logic [SEL_W-1:0]  index;

  logic [SEL_W:0]    scan_from;
  logic              scan_found;
  logic [SEL_W-1:0]  scan_hit;
  logic              phase_last;

  // Lowest enabled register at or above the scan start; the downward loop leaves the lowest hit.
  always_comb begin
    scan_from  = (state == PRE_D) ? '0 : ({1'b0, index} + (SEL_W+1)'(1));
    scan_found = 1'b0;
    scan_hit   = '0;
    for (int j = N_REGS - 1; j >= 0; j--) begin
      if (mask[j] && (j >= int'(scan_from))) begin
        scan_found = 1'b1;
        scan_hit   = SEL_W'(j);
      end
    end
  end

  assign phase_last = (phase_cnt == PH_LAST);

  // Outputs are decoded from the current state, so they trail the state register by one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      mask          <= '0;
      phase_cnt     <= '0;
      index         <= '0;
      bus.busy      <= 1'b0;
      bus.fin       <= 1'b0;
      bus.op        <= 1'b0;
      bus.wr        <= 1'b0;
      bus.ad        <= 1'b0;
      bus.addr_out  <= '0;
      bus.sel_prog  <= '0;
      bus.data_sel  <= 2'b10;
      bus.init_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mask      <= bus.reg_mask;
            index     <= '0;
            phase_cnt <= '0;
            state     <= PRE_A;
          end
        end
        PRE_A, REG_A: begin
          if (phase_last) begin
            phase_cnt <= '0;
            state     <= (state == PRE_A) ? PRE_D : REG_D;
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        PRE_D, REG_D: begin
          if (phase_last) begin
            phase_cnt <= '0;
            if (scan_found && !(state == REG_D && index == IDX_LAST)) begin
              index <= scan_hit;
              state <= REG_A;
            end else begin
              state <= FIN;
            end
          end else begin
            phase_cnt <= phase_cnt + PH_W'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      bus.busy     <= (state != IDLE);
      bus.fin      <= (state == FIN);
      bus.op       <= 1'b0;
      bus.wr       <= 1'b0;
      bus.ad       <= 1'b0;
      bus.addr_out <= '0;
      bus.sel_prog <= '0;
      bus.data_sel <= 2'b10;
      case (state)
        PRE_A, PRE_D: begin
          bus.op       <= 1'b1;
          bus.wr       <= 1'b1;
          bus.ad       <= (state == PRE_D);
          bus.addr_out <= ADDR_W'(CTRL_ADDR);
          bus.data_sel <= 2'b01;
        end
        REG_A, REG_D: begin
          bus.op       <= 1'b1;
          bus.wr       <= 1'b1;
          bus.ad       <= (state == REG_D);
          bus.addr_out <= ADDR_W'(BASE_ADDR + int'(index));
          bus.sel_prog <= index;
          bus.data_sel <= 2'b11;
        end
        default: ;
      endcase

`ifdef RTC_SEQ_READ_KICK_EN
      bus.init_read <= bus.fin;
`else
      bus.init_read <= 1'b0;
`endif
    end
  end

endmodule
